// File: rtl/rv_dmem_responder_pkg.sv
// rv_mem_pkg
// Shared constants and types for the data-memory responder: the decoded
// addresses of the MMIO page, the completion magic value, the responder
// state enum and a helper that packs the console STATUS word.
package rv_mem_pkg;

    localparam logic [31:0] ADDR_HALT    = 32'h0000_FFFF;
    localparam logic [31:0] ADDR_CONSOLE = 32'h0000_FF00;
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_FF04;
    localparam logic [31:0] ADDR_CYCLES  = 32'h0000_FF08;
    // dmem_addr[31:8] value that selects the MMIO page.
    localparam logic [23:0] MMIO_PAGE    = 24'h0000FF;

    localparam logic [31:0] HALT_MAGIC   = 32'h0000_DEAD;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } resp_state_t;

    // STATUS layout: bit0 full, bit1 empty, bits[4:2] count, bit5 overflow.
    function automatic logic [31:0] pack_status(input logic       full,
                                                input logic       empty,
                                                input logic [2:0] count,
                                                input logic       overflow);
        return {26'd0, overflow, count, empty, full};
    endfunction

endpackage

// File: rtl/rv_dmem_responder_console_fifo.sv
// console_fifo
// Small synchronous FIFO feeding the console sink.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   push, push_data   write side; a push is taken when not full, or when a
//                     pop happens in the same cycle
//   pop_ready         sink ready
//   head_data         entry at the head (0 while empty)
//   head_valid        FIFO non-empty
//   count             number of stored entries (0..DEPTH)
//   full, empty       occupancy flags
//   overflow          sticky: a push was dropped; cleared only by reset
//
// Handshake: head_valid/head_data form a valid/ready source. head_valid does
// not depend on pop_ready, head_data is stable while head_valid is high and
// pop_ready is low, and a transfer (pop) happens on every edge where both
// head_valid and pop_ready are high.
module console_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop_ready,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             pop;
    logic             push_ok;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign head_valid = !empty;
    // Gate the head so the sink sees 0 rather than stale storage when empty.
    assign head_data  = empty ? '0 : mem[rd_ptr];

    assign pop     = head_valid && pop_ready;
    // When full, a same-cycle pop frees the slot the push will overwrite;
    // the head was already read combinationally in this cycle.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is not reset; the empty gate on head_data hides its contents.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rv_dmem_responder.sv
// rv_dmem_responder
// Responder end of the core's data-memory interface. Decodes each access
// into HALT, MMIO or RAM, returns read data combinationally and commits
// writes on the clock edge. Holds the word RAM, the console FIFO, a
// free-running cycle counter and the RUN/HALTED completion state.
//
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   dmem_addr      byte address from the core
//   dmem_dataout   write data from the core
//   memrw          1 = write this cycle
//   dmem_datain    read data to the core (combinational)
//   tx_data        console byte at the FIFO head
//   tx_valid       FIFO non-empty
//   tx_ready       sink accepts tx_data
//   halted         completion sequence seen (sticky until reset)
module rv_dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int DPWIDTH    = 32,
    parameter int LOGDEPTH   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_dataout,
    input  logic               memrw,
    output logic [DPWIDTH-1:0] dmem_datain,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               halted
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    resp_state_t state_q;
    resp_state_t state_d;

    logic [DPWIDTH-1:0] ram [2**LOGDEPTH];
    logic [LOGDEPTH-1:0] ram_idx;
    logic [31:0]         cycles_q;

    logic          is_halt;
    logic          is_mmio;
    logic          wr_ok;
    logic          ram_we;
    logic          fifo_push;
    logic          cycles_clear;
    logic          halt_hit;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_overflow;

    // HALT is checked first because 0xFFFF also lies inside the MMIO page.
    assign is_halt = (dmem_addr == ADDR_HALT);
    assign is_mmio = !is_halt && (dmem_addr[31:8] == MMIO_PAGE);
    assign ram_idx = dmem_addr[LOGDEPTH+1:2];

    // Every write effect is suppressed in HALTED and while reset is asserted.
    assign wr_ok        = memrw && rst && (state_q == S_RUN);
    assign ram_we       = wr_ok && !is_halt && !is_mmio;
    assign fifo_push    = wr_ok && (dmem_addr == ADDR_CONSOLE);
    assign cycles_clear = wr_ok && (dmem_addr == ADDR_CYCLES);
    assign halt_hit     = wr_ok && is_halt && (dmem_dataout == HALT_MAGIC);

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        halted  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (halt_hit) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // ---------------- RAM ----------------
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= dmem_dataout;
        end
    end

    // ---------------- cycle counter ----------------
    // A clearing write wins over the increment; frozen while HALTED.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycles_q <= '0;
        end else if (cycles_clear) begin
            cycles_q <= '0;
        end else if (state_q == S_RUN) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    // ---------------- console FIFO ----------------
    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_console_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  (dmem_dataout[7:0]),
        .pop_ready  (tx_ready),
        .head_data  (tx_data),
        .head_valid (tx_valid),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .overflow   (fifo_overflow)
    );

    // ---------------- read mux ----------------
    always_comb begin
        dmem_datain = '0;
        if (is_halt) begin
            dmem_datain = '0;
        end else if (is_mmio) begin
            if (dmem_addr == ADDR_STATUS) begin
                dmem_datain = DPWIDTH'(pack_status(fifo_full, fifo_empty,
                                                   3'(fifo_count), fifo_overflow));
            end else if (dmem_addr == ADDR_CYCLES) begin
                dmem_datain = DPWIDTH'(cycles_q);
            end
        end else begin
            dmem_datain = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_rv_dmem_responder.sv
// tb_rv_dmem_responder
// Self-checking bench for rv_dmem_responder. A behavioural model (RAM map,
// byte queue, counter, halted flag) is stepped once per clock from the
// memory-map rules; directed steps add fixed expected values on top.
module tb_rv_dmem_responder;

    localparam int LOGDEPTH   = 10;
    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_dataout;
    logic        memrw;
    logic [31:0] dmem_datain;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;

    rv_dmem_responder #(
        .DPWIDTH    (32),
        .LOGDEPTH   (LOGDEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_addr    (dmem_addr),
        .dmem_dataout (dmem_dataout),
        .memrw        (memrw),
        .dmem_datain  (dmem_datain),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .halted       (halted)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ram_m [int];
    logic [7:0]  q_m [$];
    logic [7:0]  rx_log [$];
    bit          ovf_m;
    bit          halted_m;
    logic [31:0] cyc_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int ram_index(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << LOGDEPTH));
    endfunction

    function automatic bit is_mmio_addr(input logic [31:0] a);
        return (a != 32'hFFFF) && ((a >> 8) == 32'hFF);
    endfunction

    function automatic logic [31:0] status_m();
        int n;
        n = q_m.size();
        return 32'((int'(ovf_m) << 5) + (n << 2) + (int'(n == 0) << 1) + int'(n == FIFO_DEPTH));
    endfunction

    // Returns 1 when the model knows the value a read of 'a' must return.
    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        v = 32'h0;
        if (a == 32'hFFFF) return 1'b1;
        if (is_mmio_addr(a)) begin
            if (a == 32'hFF04) v = status_m();
            else if (a == 32'hFF08) v = cyc_m;
            return 1'b1;
        end
        if (ram_m.exists(ram_index(a))) begin
            v = ram_m[ram_index(a)];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d,
                              input bit rw, input bit rdy);
        bit clr;
        bit halt_next;
        clr = 1'b0;
        halt_next = halted_m;
        if (q_m.size() > 0 && rdy) void'(q_m.pop_front());
        if (rw && !halted_m) begin
            if (a == 32'hFFFF) begin
                if (d == 32'hDEAD) halt_next = 1'b1;
            end else if (is_mmio_addr(a)) begin
                if (a == 32'hFF00) begin
                    if (q_m.size() < FIFO_DEPTH) q_m.push_back(d[7:0]);
                    else ovf_m = 1'b1;
                end else if (a == 32'hFF08) begin
                    clr = 1'b1;
                end
            end else begin
                ram_m[ram_index(a)] = d;
            end
        end
        if (clr) cyc_m = 32'h0;
        else if (!halted_m) cyc_m = cyc_m + 32'd1;
        halted_m = halt_next;
    endtask

    // One clock: drive, check outputs at the falling edge, commit at the rising edge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input bit rw,
                        input bit rdy, input bit has_exp = 1'b0,
                        input logic [31:0] exp_v = 32'h0, input string tag = "read");
        logic [31:0] mv;
        dmem_addr    = a;
        dmem_dataout = d;
        memrw        = rw;
        tx_ready     = rdy;
        @(negedge clk);
        check("tx_valid", {31'd0, tx_valid}, {31'd0, q_m.size() != 0});
        check("tx_data", {24'd0, tx_data}, {24'd0, (q_m.size() != 0) ? q_m[0] : 8'h00});
        check("halted", {31'd0, halted}, {31'd0, halted_m});
        if (model_read(a, mv)) check("model_rdata", dmem_datain, mv);
        if (has_exp) check(tag, dmem_datain, exp_v);
        if (tx_valid && rdy) rx_log.push_back(tx_data);
        @(posedge clk);
        model_edge(a, d, rw, rdy);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] a, input logic [31:0] d, input bit rw);
        rst          = 1'b0;
        dmem_addr    = a;
        dmem_dataout = d;
        memrw        = rw;
        tx_ready     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_m.delete();
        ovf_m    = 1'b0;
        halted_m = 1'b0;
        cyc_m    = 32'h0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] frozen;
        bit          rw;
        int          sel;
        logic [7:0]  exp_bytes [$];

        rst = 1'b0; dmem_addr = '0; dmem_dataout = '0; memrw = 1'b0; tx_ready = 1'b0;
        do_reset(32'h0, 32'h0, 1'b0);

        // Reset state
        check("rst0_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst0_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst0_halted", {31'd0, halted}, 32'd0);
        step(32'hFF04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h02, "rst0_status");
        step(32'hFF08, 32'h0, 1'b0, 1'b0, 1'b1, 32'h01, "rst0_cycles");

        // RAM round trip and alias
        step(32'h40, 32'h1234_5678, 1'b1, 1'b0);
        step(32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, "ram_rd");
        step(32'h40 + (32'd4 << LOGDEPTH), 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, "ram_alias");
        step(32'h43, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, "ram_lowbits");
        step(32'hFFFF, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, "halt_rd");
        step(32'hFF00, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, "console_rd");

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 4; i++) step(32'hFF00, 32'h41 + i, 1'b1, 1'b0);
        step(32'hFF04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11, "full_status");
        step(32'hFF00, 32'h55, 1'b1, 1'b1);
        step(32'hFF04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11, "pushpop_status");
        rx_log.delete();
        for (int i = 0; i < 5; i++) step(32'hFF04, 32'h0, 1'b0, 1'b1);
        exp_bytes = '{8'h42, 8'h43, 8'h44, 8'h55};
        check("pushpop_rx_count", rx_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < rx_log.size(); i++)
            check("pushpop_rx_byte", {24'd0, rx_log[i]}, {24'd0, exp_bytes[i]});
        step(32'hFF04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h02, "pushpop_drained");

        // Console burst with the sink stalled
        rx_log.delete();
        for (int i = 0; i < 5; i++) step(32'hFF00, 32'h41 + i, 1'b1, 1'b0);
        step(32'hFF04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h31, "burst_status");
        for (int i = 0; i < 6; i++) step(32'h0, 32'h0, 1'b0, 1'b1);
        exp_bytes = '{8'h41, 8'h42, 8'h43, 8'h44};
        check("burst_rx_count", rx_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < rx_log.size(); i++)
            check("burst_rx_byte", {24'd0, rx_log[i]}, {24'd0, exp_bytes[i]});
        step(32'hFF04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h22, "burst_end_status");

        // Cycle counter: clear, then ten edges later it reads 10
        step(32'hFF08, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
        step(32'hFF08, 32'h0, 1'b0, 1'b0, 1'b1, 32'd10, "cycles_10");
        // Back-to-back clears: the clear wins over the increment
        step(32'hFF08, 32'h0, 1'b1, 1'b0);
        step(32'hFF08, 32'h0, 1'b1, 1'b0, 1'b1, 32'd0, "cycles_clear1");
        step(32'hFF08, 32'h0, 1'b0, 1'b0, 1'b1, 32'd0, "cycles_clear2");
        step(32'hFF08, 32'h0, 1'b0, 1'b0, 1'b1, 32'd1, "cycles_restart");

        // Randomized mix checked against the model
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            rw  = 1'b0;
            d   = $urandom;
            case (sel)
                0, 1, 2, 3, 4: begin
                    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
                        | (32'($urandom_range(0, 3)) << (LOGDEPTH + 2));
                    rw = (sel < 3);
                end
                5, 6: begin a = 32'hFF00; rw = 1'b1; end
                7:    a = 32'hFF04;
                8: begin a = 32'hFF08; rw = ($urandom_range(0, 7) == 0); end
                default: begin
                    a  = 32'hFF00 | 32'($urandom_range(0, 255));
                    rw = $urandom_range(0, 1);
                    if (a == 32'hFFFF) d = 32'hBEEF;
                end
            endcase
            step(a, d, rw, 1'($urandom_range(0, 1)));
        end

        // Completion sequence
        do_reset(32'h0, 32'h0, 1'b0);
        step(32'h0, 32'hA5A5_A5A5, 1'b1, 1'b0);
        step(32'hFF00, 32'h61, 1'b1, 1'b0);
        step(32'hFF00, 32'h62, 1'b1, 1'b0);
        step(32'hFFFF, 32'hBEEF, 1'b1, 1'b0);
        check("beef_halted", {31'd0, halted}, 32'd0);
        step(32'hFFFF, 32'hDEAD, 1'b1, 1'b0);
        check("dead_halted", {31'd0, halted}, 32'd1);
        frozen = cyc_m;
        step(32'h0, 32'h1111_1111, 1'b1, 1'b0);
        step(32'hFF08, 32'h0, 1'b1, 1'b0);
        step(32'hFF00, 32'h77, 1'b1, 1'b0);
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, "halted_ram");
        step(32'hFF08, 32'h0, 1'b0, 1'b0, 1'b1, frozen, "halted_cycles");
        step(32'hFF04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h08, "halted_status");

        // Reset mid-operation; the write presented during reset is dropped
        do_reset(32'h0, 32'hDEAD_BEEF, 1'b1);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        step(32'hFF04, 32'h0, 1'b0, 1'b0, 1'b1, 32'h02, "rst_status");
        step(32'hFF08, 32'h0, 1'b0, 1'b0, 1'b1, 32'd1, "rst_cycles1");
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, "rst_ram_kept");
        step(32'hFF08, 32'h0, 1'b0, 1'b0, 1'b1, 32'd3, "rst_cycles3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_dmem_responder.md
# rv_dmem_responder

Responder end of the multicycle RISC-V core's data-memory interface: it accepts the core's address/write-data/memrw and returns read data. It holds a word-addressed data RAM plus a small memory-mapped I/O page with a console transmit FIFO, a free-running cycle counter and the 0xDEAD→0xFFFF completion detector. It sits beside `rv_top` in both synthesis tops and simulation benches, replacing the ad hoc memory array.

## Interface
Parameters:
- `DPWIDTH`, 32, datapath width; only 32 is supported.
- `LOGDEPTH`, 10, log2 of the RAM depth in 32-bit words.
- `FIFO_DEPTH`, 4, console FIFO entries; must be a power of two.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-low.
- `dmem_addr`  in  32  byte address from the core.
- `dmem_dataout`  in  32  write data from the core.
- `memrw`  in  1  write strobe from the core (1 = write this cycle).
- `dmem_datain`  out  32  read data to the core; combinational.
- `tx_data`  out  8  console byte at the FIFO head.
- `tx_valid`  out  1  FIFO is non-empty.
- `tx_ready`  in  1  sink accepts `tx_data`.
- `halted`  out  1  completion sequence seen; sticky.

## Operation
- **Decode order:**
  - `dmem_addr == 32'h0000FFFF`: HALT.
  - Otherwise `dmem_addr[31:8] == 24'h0000FF`: MMIO.
  - Otherwise: RAM.
- **RAM:**
  - Index is `dmem_addr[LOGDEPTH+1:2]`; upper bits are ignored, so addresses alias and wrap.
  - Low two bits are ignored; accesses are aligned words only.
  - Reads are combinational. A write commits on the clock edge when `memrw` is high.
  - RAM contents are not reset. Benches preload them with `$readmemh`.
- **MMIO page:**
  - 0xFF00 CONSOLE:
    - Write pushes `dmem_dataout[7:0]` into the FIFO.
    - Read returns 0.
  - 0xFF04 STATUS (read-only):
    - bit0 full, bit1 empty.
    - bits[4:2] count (0..4).
    - bit5 overflow. Overflow is sticky and cleared only by reset.
    - All other bits read 0.
  - 0xFF08 CYCLES:
    - Read returns the 32-bit counter.
    - Any write clears the counter to 0.
  - Any other MMIO offset reads 0; writes to it are ignored.
- **HALT address:**
  - A write of `32'h0000DEAD` sets `halted`.
  - A write of any other value is ignored.
  - Read returns 0.
- **State machine (two states):**
  - RUN → HALTED on the edge where a HALT write with 0xDEAD occurs.
  - HALTED → RUN only on reset.
  - In HALTED:
    - All writes are ignored (RAM, CONSOLE, CYCLES).
    - The counter is frozen.
    - Reads still work.
    - The FIFO keeps draining to the sink.
- **Cycle counter:**
  - Increments by 1 every RUN cycle and wraps at 2^32.
  - A clearing write takes priority over the increment: the value is 0 on the next cycle.
- **FIFO:**
  - `tx_valid = !empty`; `tx_data` is the head entry.
  - A pop happens when `tx_valid && tx_ready`.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A push that is not accepted is dropped and sets overflow.
  - Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Read data is valid in the same cycle as the address; there is no wait state.
- Write effects (RAM contents, FIFO count, counter clear, `halted`) are visible from the cycle after the `memrw` edge.
- Push into an empty FIFO: `tx_valid` rises the next cycle. There is no bypass.
- Values after reset (`rst` low at an edge):
  - FIFO empty, pointers 0, `tx_valid` 0, `tx_data` 0.
  - overflow 0, counter 0, state RUN, `halted` 0.
- Reset mid-transfer discards FIFO contents; RAM keeps its contents.
- A write presented while `rst` is low is ignored.

## Structure
- Package `rv_mem_pkg` holds:
  - the address constants `ADDR_HALT`, `ADDR_CONSOLE`, `ADDR_STATUS`, `ADDR_CYCLES` and `MMIO_PAGE`;
  - `HALT_MAGIC = 32'hDEAD`;
  - enum `resp_state_t {S_RUN, S_HALTED}`.
- Sub-module `console_fifo`: parameterised synchronous FIFO with push/pop, `count`, `full` and `empty` outputs and an overflow flag.
- The top holds the decoder, RAM array, counter and state register.

## Test plan
- **RAM round trip:** write 0x12345678 to 0x40, then read 0x40 and 0x40+(4<<LOGDEPTH) → both reads return 0x12345678 (alias check).
- **Console burst with sink stalled:**
  - Steps: hold `tx_ready`=0 and write 0x41..0x45 to 0xFF00.
  - Required: STATUS = 0x31 (full, count 4, overflow).
  - Then raise `tx_ready`: the sink receives 0x41,0x42,0x43,0x44 in order; STATUS ends at 0x22.
- **Full FIFO, push and pop together:** with the FIFO full and `tx_ready`=1, write 0x55 → push accepted, count stays 4, overflow stays 0.
- **Cycle counter:**
  - Steps: write 0xFF08, then read 0xFF08 after 10 cycles.
  - Required: the read returns 10 (±1 per the documented edge). A write in the same cycle as a wrap from 0xFFFFFFFF yields 0.
- **Completion:**
  - Steps: write 0xBEEF to 0xFFFF; then write 0xDEAD to 0xFFFF; then write to RAM 0x0 and write 0xFF08.
  - Required: 0xBEEF leaves `halted`=0. 0xDEAD sets `halted`=1 on the next cycle. The later RAM write leaves RAM unchanged and the counter stays frozen.
- **Reset mid-operation:**
  - Steps: pulse `rst` low while the FIFO holds 2 bytes and `halted`=1.
  - Required: `tx_valid`=0, `halted`=0, STATUS=0x02, counter restarts from 0, RAM contents preserved.
